// File: rtl/uart_tx_drain_if.sv
// Link between the FIFO-draining UART transmitter and its surroundings:
// FIFO read side plus the serial line and frame status.
interface uart_tx_drain_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that pulls bytes from an upstream FIFO and frames them as
// start, 8 data bits LSB first, optional even parity, and 1 or 2 stop bits.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 1252,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_drain_if.master link
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [CNT_W-1:0] baud_next;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_next;
    logic             bit_term;
    logic             bit_term_next;
    logic             stop_cnt;
    logic             stop_next;
    logic [7:0]       shift_reg;
    logic [7:0]       shift_next;
    logic             parity_reg;
    logic             parity_next;
    logic             baud_wrap;

    logic             tx_q;
    logic             fifo_rd_q;
    logic             busy_q;
    logic             tx_done_q;
    logic             tx_d;
    logic             tx_done_d;

    function automatic logic line_level(input state_t s, input logic data_lsb, input logic par_bit);
        case (s)
            START:   line_level = 1'b0;
            DATA:    line_level = data_lsb;
            PARITY:  line_level = par_bit;
            default: line_level = 1'b1;
        endcase
    endfunction

    always_comb begin
        state_next    = state;
        baud_next     = baud_cnt;
        bit_next      = bit_cnt;
        bit_term_next = bit_term;
        stop_next     = stop_cnt;
        shift_next    = shift_reg;
        parity_next   = parity_reg;
        baud_wrap     = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                if (!link.fifo_empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                shift_next    = link.fifo_data;
                parity_next   = ^link.fifo_data;
                baud_next     = '0;
                bit_next      = '0;
                bit_term_next = 1'b0;
                stop_next     = 1'b0;
                state_next    = START;
            end
            START: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_next                 = '0;
                    shift_next                = {1'b0, shift_reg[7:1]};
                    {bit_term_next, bit_next} = {1'b0, bit_cnt} + 4'd1;
                    // The terminal flag marks the eighth bit; the count only restarts in LOAD.
                    if (bit_term_next) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (baud_wrap) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_next = '0;
                    if (stop_cnt == STOP_LAST) begin
                        state_next = link.fifo_empty ? IDLE : FETCH;
                    end else begin
                        stop_next = 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it cycle for cycle.
        tx_d      = line_level(state_next, shift_next[0], parity_next);
        tx_done_d = (state_next == STOP) && (baud_next == BAUD_LAST) && (stop_next == STOP_LAST);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            bit_term  <= 1'b0;
            stop_cnt  <= 1'b0;
            tx_q      <= 1'b1;
            fifo_rd_q <= 1'b0;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            bit_term  <= bit_term_next;
            stop_cnt  <= stop_next;
            tx_q      <= tx_d;
            fifo_rd_q <= (state_next == FETCH);
            busy_q    <= (state_next != IDLE);
            tx_done_q <= tx_done_d;
        end
    end

    // Byte and parity holding registers carry no control meaning and skip reset.
    always_ff @(posedge clock) begin
        shift_reg  <= shift_next;
        parity_reg <= parity_next;
    end

    assign link.tx      = tx_q;
    assign link.fifo_rd = fifo_rd_q;
    assign link.busy    = busy_q;
    assign link.tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: three configurations behind one FIFO model and one
// line receiver, selected one at a time, scored against a byte queue.
module tb_uart_tx_drain;

    localparam int CPB = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    uart_tx_drain_if bus0 ();
    uart_tx_drain_if bus1 ();
    uart_tx_drain_if bus2 ();

    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
        .clock(clock), .reset(reset), .link(bus0));
    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
        .clock(clock), .reset(reset), .link(bus1));
    uart_tx_drain #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
        .clock(clock), .reset(reset), .link(bus2));

    int         sel = 0;
    logic       q_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic       par_q[$];

    assign bus0.fifo_empty = (sel == 0) ? q_empty : 1'b1;
    assign bus1.fifo_empty = (sel == 1) ? q_empty : 1'b1;
    assign bus2.fifo_empty = (sel == 2) ? q_empty : 1'b1;
    assign bus0.fifo_data  = fifo_data;
    assign bus1.fifo_data  = fifo_data;
    assign bus2.fifo_data  = fifo_data;

    logic tx_m, busy_m, rd_m, done_m;
    always_comb begin
        case (sel)
            1: begin tx_m = bus1.tx; busy_m = bus1.busy; rd_m = bus1.fifo_rd; done_m = bus1.tx_done; end
            2: begin tx_m = bus2.tx; busy_m = bus2.busy; rd_m = bus2.fifo_rd; done_m = bus2.tx_done; end
            default: begin tx_m = bus0.tx; busy_m = bus0.busy; rd_m = bus0.fifo_rd; done_m = bus0.tx_done; end
        endcase
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // FIFO model: read data appears the cycle after the strobe.
    always @(posedge clock) begin
        logic [7:0] b;
        if (rd_m && fifo_q.size() != 0) begin
            b = fifo_q.pop_front();
            fifo_data <= b;
        end
        q_empty <= (fifo_q.size() == 0);
    end

    task automatic fifo_push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
    endtask

    int         ncyc = 0, rx_t = 0, zeros = 0, ones = 0, dones = 0;
    int         end_cyc = 0, rx_frames = 0, rd_total = 0, rd_viol = 0, stray_done = 0;
    int         last_zeros = 0, last_ones = 0, gap_base = 0;
    logic       rx_active = 1'b0, gap_low = 1'b0, chk_gap = 1'b0;
    logic [7:0] exp_b = 8'h00;

    // Line receiver: detects the start edge, samples mid-bit, scores against exp_q.
    always @(negedge clock) begin
        int bi, nb;
        nb = 9 + ((sel == 1) ? 1 : 0) + ((sel == 2) ? 2 : 1);
        ncyc++;
        if (rd_m) begin
            rd_total++;
            if (q_empty) rd_viol++;
        end
        if (!reset) begin
            rx_active = 1'b0;
            gap_low   = 1'b0;
        end else begin
            if (!rx_active) begin
                if (done_m) stray_done++;
                if (!busy_m) gap_low = 1'b1;
                if (!tx_m) begin
                    rx_active = 1'b1;
                    rx_t = 0; zeros = 0; ones = 0; dones = 0;
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_frame", 1, 0);
                        exp_b = 8'h00;
                    end else begin
                        exp_b = exp_q.pop_front();
                    end
                    if (chk_gap && rx_frames > gap_base) begin
                        check_eq("gap_cycles", ncyc - end_cyc - 1, 2);
                        check_eq("busy_gap", int'(gap_low), 0);
                    end
                    gap_low = 1'b0;
                end
            end
            if (rx_active) begin
                if (tx_m) ones++; else zeros++;
                if (done_m) begin
                    dones++;
                    check_eq("frame_len", rx_t + 1, nb * CPB);
                end
                if (rx_t % CPB == CPB / 2) begin
                    bi = rx_t / CPB;
                    check_eq("busy_in_frame", int'(busy_m), 1);
                    if (bi == 0) check_eq("start_bit", int'(tx_m), 0);
                    else if (bi <= 8) check_eq("data_bit", int'(tx_m), int'(exp_b[bi-1]));
                    else if (sel == 1 && bi == 9) begin
                        check_eq("parity_bit", int'(tx_m), int'(^exp_b));
                        par_q.push_back(tx_m);
                    end else check_eq("stop_bit", int'(tx_m), 1);
                end
                if (rx_t == nb * CPB - 1) begin
                    check_eq("done_count", dones, 1);
                    last_zeros = zeros;
                    last_ones  = ones;
                    rx_frames++;
                    end_cyc   = ncyc;
                    rx_active = 1'b0;
                end else begin
                    rx_t++;
                end
            end
        end
    end

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !rx_active && !busy_m) && n < max_cyc);
        check_eq("drain_timeout", int'(n >= max_cyc), 0);
    endtask

    initial begin
        int base_rd, base_fr, idle_bad, n;
        logic p;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_tx", int'(tx_m), 1);
        check_eq("rst_busy", int'(busy_m), 0);
        check_eq("rst_rd", int'(rd_m), 0);
        check_eq("rst_done", int'(done_m), 0);
        check_eq("rst_tx_par", int'(bus1.tx), 1);
        check_eq("rst_tx_s2", int'(bus2.tx), 1);
        reset = 1'b1;

        // Empty FIFO for 100 cycles: the line must stay quiet.
        base_rd = rd_total;
        idle_bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (rd_m || !tx_m || busy_m) idle_bad++;
        end
        check_eq("idle_quiet", idle_bad, 0);
        check_eq("idle_rd", rd_total - base_rd, 0);

        // Single 0xA5, no parity, one stop bit, with latency checks.
        sel = 0;
        base_rd = rd_total;
        fifo_push(8'hA5);
        @(negedge clock);
        check_eq("lat_pre_rd", int'(rd_m), 0);
        @(negedge clock);
        check_eq("lat_fetch_rd", int'(rd_m), 1);
        check_eq("lat_fetch_busy", int'(busy_m), 1);
        @(negedge clock);
        check_eq("lat_load_rd", int'(rd_m), 0);
        check_eq("lat_load_tx", int'(tx_m), 1);
        @(negedge clock);
        check_eq("lat_start_tx", int'(tx_m), 0);
        wait_idle(200);
        check_eq("a5_rd_count", rd_total - base_rd, 1);
        check_eq("a5_idle_busy", int'(busy_m), 0);
        check_eq("a5_idle_tx", int'(tx_m), 1);

        // Parity enabled, 0xA5 then 0x07 back to back.
        repeat (5) @(negedge clock);
        sel = 1;
        par_q.delete();
        gap_base = rx_frames;
        chk_gap = 1'b1;
        base_rd = rd_total;
        base_fr = rx_frames;
        fifo_push(8'hA5);
        fifo_push(8'h07);
        wait_idle(400);
        check_eq("par_frames", rx_frames - base_fr, 2);
        check_eq("par_rd_count", rd_total - base_rd, 2);
        check_eq("par_samples", par_q.size(), 2);
        if (par_q.size() == 2) begin
            p = par_q.pop_front();
            check_eq("parity_a5", int'(p), 0);
            p = par_q.pop_front();
            check_eq("parity_07", int'(p), 1);
        end
        chk_gap = 1'b0;

        // Two stop bits, 0x00.
        repeat (5) @(negedge clock);
        sel = 2;
        base_fr = rx_frames;
        fifo_push(8'h00);
        wait_idle(200);
        check_eq("s2_frames", rx_frames - base_fr, 1);
        check_eq("s2_zero_cycles", last_zeros, 36);
        check_eq("s2_one_cycles", last_ones, 8);

        // Reset during the third data bit of 0xFF, then a fresh frame.
        repeat (5) @(negedge clock);
        sel = 1;
        base_rd = rd_total;
        base_fr = rx_frames;
        fifo_push(8'hFF);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(rx_active && rx_t >= 3 * CPB + 1) && n < 200);
        check_eq("rst_wait_timeout", int'(n >= 200), 0);
        fifo_push(8'h3C);
        reset = 1'b0;
        @(negedge clock);
        check_eq("midrst_tx", int'(tx_m), 1);
        check_eq("midrst_busy", int'(busy_m), 0);
        check_eq("midrst_rd", int'(rd_m), 0);
        reset = 1'b1;
        wait_idle(300);
        check_eq("midrst_frames", rx_frames - base_fr, 1);
        check_eq("midrst_rd_count", rd_total - base_rd, 2);

        // Sixteen random bytes queued at once.
        repeat (5) @(negedge clock);
        sel = 1;
        gap_base = rx_frames;
        chk_gap = 1'b1;
        base_rd = rd_total;
        base_fr = rx_frames;
        for (int i = 0; i < 16; i++) fifo_push(8'($urandom_range(0, 255)));
        wait_idle(2000);
        chk_gap = 1'b0;
        check_eq("rand_frames", rx_frames - base_fr, 16);
        check_eq("rand_rd_count", rd_total - base_rd, 16);
        check_eq("rand_left", exp_q.size(), 0);

        check_eq("rd_while_empty", rd_viol, 0);
        check_eq("stray_done", stray_done, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
